// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a 2-entry valid/ready result buffer
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [3:0] ALU_AND       = 4'b0000;
  localparam logic [3:0] ALU_OR        = 4'b0001;
  localparam logic [3:0] ALU_SUBTRACT  = 4'b0110;
  localparam logic [3:0] ALU_LESS_THAN = 4'b0111;
  localparam logic [3:0] ALU_NOR       = 4'b1100;
  localparam int E = WIDTH + 2 + TAG_W;
  logic [WIDTH-1:0] sum, diff, res;
  logic             lt, ovf, accept, pop, rd, wr;
  logic [1:0]       count, cnt_nxt;
  logic [E-1:0]     mem [2];
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  // direct signed compare stays correct when a-b overflows
  assign lt   = $signed(op_a) < $signed(op_b);
  always_comb begin
    res = alu_ctrl == ALU_AND       ? op_a & op_b :
          alu_ctrl == ALU_OR        ? op_a | op_b :
          alu_ctrl == ALU_NOR       ? ~(op_a | op_b) :
          alu_ctrl == ALU_SUBTRACT  ? diff :
          alu_ctrl == ALU_LESS_THAN ? {{(WIDTH-1){1'b0}}, lt} : sum;
    ovf = alu_ctrl == ALU_SUBTRACT ? (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]) :
          (alu_ctrl == ALU_AND || alu_ctrl == ALU_OR || alu_ctrl == ALU_NOR || alu_ctrl == ALU_LESS_THAN) ? 1'b0 :
          (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end
  assign accept    = in_valid && in_ready;
  assign out_valid = count != 2'd0;
  assign pop       = out_valid && out_ready;
  assign cnt_nxt   = count + {1'b0, accept} - {1'b0, pop};
  assign {result, zero, overflow, out_tag} = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      count    <= 2'd0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      in_ready <= cnt_nxt < 2'd2;
      count    <= cnt_nxt;
      if (accept) begin
        mem[wr] <= {res, res == '0, ovf, in_tag};
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized and directed checks of alu_exec_stage against a queue-based reference model
module tb_alu_exec_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid, zero, overflow;
  logic [31:0] result;
  logic [4:0]  out_tag;
  typedef struct { logic [31:0] r; logic z; logic v; logic [4:0] t; } exp_t;
  exp_t q[$];
  bit   m_rdy = 1'b0;
  int   n_vec = 0, n_err = 0;
  logic [3:0]  codes [7] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hF};
  logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tg, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    exp_t e;
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    e.v = 1'b0;
    e.t = t;
    case (c)
      4'h0: e.r = a & b;
      4'h1: e.r = a | b;
      4'hC: e.r = ~(a | b);
      4'h7: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'h6: begin s = sa - sb; e.r = s[31:0]; e.v = s > 64'sd2147483647 || s < -64'sd2147483648; end
      default: begin s = sa + sb; e.r = s[31:0]; e.v = s > 64'sd2147483647 || s < -64'sd2147483648; end
    endcase
    e.z = e.r == 32'd0;
    return e;
  endfunction

  // called between edges with inputs set; advances one clock and compares at the next negedge
  task automatic step(output bit acc);
    bit pop;
    acc = in_valid && m_rdy;
    pop = out_ready && q.size() > 0;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(ref_op(alu_ctrl, op_a, op_b, in_tag));
    if (!rst_n) q.delete();
    m_rdy = rst_n && q.size() < 2;
    @(negedge clk);
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("result", result, q[0].r);
      chk("zero", zero, q[0].z);
      chk("overflow", overflow, q[0].v);
      chk("out_tag", out_tag, q[0].t);
    end
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; in_tag = t;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bit acc = 1'b0;
    set_op(c, a, b, t);
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    chk("accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    bit acc;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {zero, overflow, out_tag}, 7'd0);
    end
    rst_n = 1'b1;
    idle(2);
    out_ready = 1'b1;
    send(4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd1);
    send(4'hC, 32'h0, 32'h0, 5'd2);
    send(4'h2, 32'd5, 32'd7, 5'd3);
    send(4'h6, 32'd5, 32'd5, 5'd4);
    send(4'h2, 32'h7FFFFFFF, 32'd1, 5'd5);
    send(4'h6, 32'h80000000, 32'd1, 5'd6);
    send(4'h7, 32'h80000000, 32'd1, 5'd7);
    send(4'h7, 32'd1, 32'hFFFFFFFF, 5'd8);
    send(4'hF, 32'd2, 32'd3, 5'd9);
    idle(2);
    out_ready = 1'b0;
    send(4'h2, 32'd1, 32'd1, 5'd10);
    send(4'h2, 32'd2, 32'd2, 5'd11);
    set_op(4'h2, 32'd3, 32'd3, 5'd12);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("held", acc, 1'b0);
    end
    out_ready = 1'b1;
    send(4'h2, 32'd3, 32'd3, 5'd12);
    idle(3);
    for (int i = 0; i < 10; i++) send(4'h2, i, 32'd100, 5'(i));
    idle(2);
    out_ready = 1'b0;
    send(4'h1, 32'h11, 32'h22, 5'd1);
    send(4'h0, 32'h33, 32'h0F, 5'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_in_ready", in_ready, 1'b0);
    #1 rst_n = 1'b1;
    q.delete();
    m_rdy = 1'b0;
    out_ready = 1'b1;
    send(4'h2, 32'd9, 32'd1, 5'd13);
    idle(3);
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 3) != 0;
        alu_ctrl = codes[$urandom_range(0, 6)];
        op_a = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 4)] : $urandom;
        op_b = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 4)] : $urandom;
        in_tag = 5'($urandom);
      end
      out_ready = $urandom_range(0, 2) != 0;
      step(acc);
    end
    out_ready = 1'b1;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute-side consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts operand pairs plus a control code through a valid/ready handshake and computes the result and flags.
- Results are held in a 2-entry output buffer with downstream valid/ready, so back-to-back ops run at full throughput under backpressure.
- Sits between decode/register-read and writeback in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits
TAG_W, 5, width of the sideband tag (destination register number) carried with each op

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  op presented on the input
in_ready  output  1  stage can accept an op this cycle
alu_ctrl  input  4  ALU control code (`ALU_AND/`ALU_OR/`ALU_ADD/`ALU_SUBTRACT/`ALU_LESS_THAN/`ALU_NOR from cpu_constant_library.v)
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  head result valid
out_ready  input  1  consumer takes the head result
result  output  WIDTH  head result
zero  output  1  head result == 0
overflow  output  1  signed overflow for ADD/SUBTRACT, else 0
out_tag  output  TAG_W  tag of the head result

Behaviour:
- One clock and one reset. Reset is asynchronous, active-low.
- Reset values:
  - Buffer count = 0.
  - in_ready = 0, out_valid = 0.
  - result, zero, overflow, out_tag = 0.
  - Rd/wr pointers = 0.
- in_ready is registered. It becomes 1 on the first clk edge after rst_n deasserts. After that, in_ready = (next count < 2).
- Accept occurs when in_valid && in_ready at a clk edge. The result is computed combinationally from alu_ctrl/op_a/op_b and written into the buffer at the same edge. Latency is 1 cycle: out_valid is high the cycle after accept if the buffer was empty.
- Pop occurs when out_valid && out_ready at a clk edge. The head advances. The next entry, if any, is presented the following cycle.
- Count update:
  - Accept and no pop: +1.
  - Pop and no accept: -1.
  - Both: count unchanged (count 1 → 1).
  - At count 2, in_ready = 0, so accept cannot coincide with count 2.
- Output stability: result, zero, overflow and out_tag are stable while out_valid && !out_ready. They are driven from buffer head registers only, never combinationally from inputs.
- Ops (WIDTH-bit, wrap-around arithmetic):
  - AND: a&b.
  - OR: a|b.
  - NOR: ~(a|b).
  - ADD: a+b.
  - SUBTRACT: a-b.
  - LESS_THAN: {0…,1} if signed a < signed b, else 0. The comparison is correct even when a-b overflows.
  - Any other code executes as ADD, matching the decoder default.
- Flags:
  - zero = (result == 0), for all ops.
  - overflow: ADD when operand signs are equal and the result sign differs. SUBTRACT when operand signs differ and the result sign differs from a. overflow = 0 for all other ops.
- Buffer is a 2-entry circular buffer. The 1-bit pointers wrap 1 → 0.
- Reset mid-operation: all buffered results are discarded, and out_valid drops immediately (async). No partial result reappears after reset.
- in_valid while in_ready = 0 is ignored. The upstream holds the op; no accept occurs.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then release → in_ready = 0 during reset, 1 one edge after release; out_valid stays 0.
- Basic ops, out_ready = 1, one op per cycle:
  - AND 0xF0F0F0F0,0xFF00FF00 → 0xF000F000.
  - NOR 0,0 → 0xFFFFFFFF.
  - ADD 5,7 tag 3 → 12, out_tag 3.
  - Each result appears exactly 1 cycle after accept, with continuous out_valid.
- Flags:
  - SUBTRACT 5,5 → 0, zero = 1.
  - ADD 0x7FFFFFFF,1 → 0x80000000, overflow = 1.
  - SUBTRACT 0x80000000,1 → 0x7FFFFFFF, overflow = 1.
  - LESS_THAN 0x80000000,1 → 1.
  - LESS_THAN 1,0xFFFFFFFF → 0.
  - Unknown code 4'b1111 on 2,3 → 5.
- Backpressure: out_ready = 0, offer 3 ops (ADD 1,1; ADD 2,2; ADD 3,3) → first two accepted, in_ready = 0 from the edge after the 2nd accept, third held. Head stays 2 with stable tag. Raise out_ready → outputs 2, 4, 6 in order, third accepted the cycle after the first pop.
- Simultaneous push/pop at count 1: out_ready = 1 with a continuous input stream of 10 ops → count stays 1, in_ready never drops, 10 results in order.
- Reset mid-operation: 2 entries buffered, pulse rst_n low between edges → out_valid = 0 immediately. After release, the first new op ADD 9,1 returns 10 and no stale entries appear.
